alu_seq: RTL and testbench

Parametrised, registered successor to the team's 4-bit combinational ALU. Adds width parameterisation, shifts, an iterative multi-cycle unsigned multiply and an illegal-opcode flag. Operands enter through a valid/ready request port; results and flags leave through a valid/ready response port. Sits between the datapath operand registers and the result write-back stage.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_mul_iter.sv | 81 ++++++++
 rtl/alu_seq.sv | 177 +++++++++++++++++
 tb/tb_alu_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// +--------------------------------------------------------------------------+
// | alu_pkg : opcode/state types and opcode classification helpers for alu_seq |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_NOT   = 4'd2,
    OP_AND   = 4'd3,
    OP_OR    = 4'd4,
    OP_XOR   = 4'd5,
    OP_SLT   = 4'd6,
    OP_EQ    = 4'd7,
    OP_SLL   = 4'd8,
    OP_SRL   = 4'd9,
    OP_SRA   = 4'd10,
    OP_MUL   = 4'd11,
    OP_ILL12 = 4'd12,
    OP_ILL13 = 4'd13,
    OP_ILL14 = 4'd14,
    OP_ILL15 = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic op_is_illegal(input op_e op);
    return (op >= OP_ILL12);
  endfunction

  // Compares and illegal opcodes never report a zero result.
  function automatic logic op_sets_zero(input op_e op);
    return !((op == OP_SLT) || (op == OP_EQ) || op_is_illegal(op));
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_mul_iter.sv
// +--------------------------------------------------------------------------+
// | alu_mul_iter : iterative shift-add unsigned multiplier, WIDTH iterations  |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] c_last_cnt = SHW'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [2*WIDTH-1:0] partial;
  logic [2*WIDTH-1:0] acc_next;

  assign partial  = mplier_q[0] ? mcand_q : '0;
  assign acc_next = acc_q + partial;

  // done and product are combinational so the final iteration's sum can be
  // captured by the parent on the same edge the last iteration completes.
  assign done    = busy_q && (cnt_q == c_last_cnt);
  assign product = acc_next;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + SHW'(1);
      if (cnt_q == c_last_cnt) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// +--------------------------------------------------------------------------+
// | alu_seq : registered parametrised ALU with valid/ready request/response   |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             cf,
  output logic             of,
  output logic             out,
  output logic             zero,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             cf_q, cf_d;
  logic             of_q, of_d;
  logic             out_q, out_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;

  op_e              op;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_c;
  logic             alu_cf, alu_of, alu_out, alu_zero, alu_err;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign op    = op_e'(sel);
  assign shamt = b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  // Carry out of a + ~b + 1 is the inverse of borrow.
  assign diff  = {1'b0, a} + {1'b0, ~b} + (WIDTH + 1)'(1);

  always_comb begin
    alu_c   = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    alu_out = 1'b0;
    alu_err = 1'b0;
    case (op)
      OP_ADD: begin
        alu_c  = sum[WIDTH-1:0];
        alu_cf = sum[WIDTH];
        alu_of = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_c  = diff[WIDTH-1:0];
        alu_cf = ~diff[WIDTH];
        alu_of = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NOT:  alu_c   = ~a;
      OP_AND:  alu_c   = a & b;
      OP_OR:   alu_c   = a | b;
      OP_XOR:  alu_c   = a ^ b;
      OP_SLT:  alu_out = ($signed(a) < $signed(b));
      OP_EQ:   alu_out = (a == b);
      OP_SLL:  alu_c   = a << shamt;
      OP_SRL:  alu_c   = a >> shamt;
      OP_SRA:  alu_c   = WIDTH'($signed(a) >>> shamt);
      OP_MUL:  alu_c   = '0;
      default: alu_err = 1'b1;
    endcase
    alu_zero = op_sets_zero(op) && (alu_c == '0);
  end

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    c_d       = c_q;
    cf_d      = cf_q;
    of_d      = of_q;
    out_d     = out_q;
    zero_d    = zero_q;
    err_d     = err_q;
    mul_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (op == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = BUSY;
          end else begin
            state_d = DONE;
            c_d     = alu_c;
            cf_d    = alu_cf;
            of_d    = alu_of;
            out_d   = alu_out;
            zero_d  = alu_zero;
            err_d   = alu_err;
          end
        end
      end
      BUSY: begin
        if (mul_done) begin
          state_d = DONE;
          c_d     = mul_product[WIDTH-1:0];
          cf_d    = 1'b0;
          of_d    = |mul_product[2*WIDTH-1:WIDTH];
          out_d   = 1'b0;
          zero_d  = (mul_product[WIDTH-1:0] == '0);
          err_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      cf_q    <= 1'b0;
      of_q    <= 1'b0;
      out_q   <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      cf_q    <= cf_d;
      of_q    <= of_d;
      out_q   <= out_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign c         = c_q;
  assign cf        = cf_q;
  assign of        = of_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// +--------------------------------------------------------------------------+
// | tb_alu_seq : directed self-checking bench for alu_seq at WIDTH=8          |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_alu_seq;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] c;
  logic             cf;
  logic             of;
  logic             out;
  logic             zero;
  logic             err;
  logic [4:0]       flags;

  int n_cmp = 0;
  int n_bad = 0;

  // Flag vector order: {cf, of, out, zero, err}
  assign flags = {cf, of, out, zero, err};

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .cf        (cf),
    .of        (of),
    .out       (out),
    .zero      (zero),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic accept(input logic [3:0] s, input logic [7:0] aa, input logic [7:0] bb);
    sel      = s;
    a        = aa;
    b        = bb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = ~aa;
    b        = ~bb;
    sel      = 4'd0;
  endtask

  task automatic wait_valid(output int lat, output logic rdy_seen);
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 40) begin
      rdy_seen = rdy_seen | in_ready;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_hs_ov"}, 32'(out_valid), 32'd0);
    check({tag, "_hs_ir"}, 32'(in_ready), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [3:0] s, input logic [7:0] aa,
                        input logic [7:0] bb, input int exp_lat, input logic [7:0] exp_c,
                        input logic [4:0] exp_f);
    int   lat;
    logic rdy_seen;
    accept(s, aa, bb);
    wait_valid(lat, rdy_seen);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy_ir"}, 32'(rdy_seen), 32'd0);
    check({tag, "_c"}, 32'(c), 32'(exp_c));
    check({tag, "_flags"}, 32'(flags), 32'(exp_f));
    handshake(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   lat;
    logic rdy_seen;
    logic ov_seen;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    sel       = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_ir", 32'(in_ready), 32'd1);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_c", 32'(c), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);

    //      tag        sel    a      b      lat c      {cf,of,out,zero,err}
    run_op("add_ovf",  4'd0,  8'h7F, 8'h01, 1, 8'h80, 5'b01000);
    run_op("add_cy",   4'd0,  8'hFF, 8'h01, 1, 8'h00, 5'b10010);
    run_op("sub_brw",  4'd1,  8'h03, 8'h05, 1, 8'hFE, 5'b10000);
    run_op("sub_ovf",  4'd1,  8'h80, 8'h01, 1, 8'h7F, 5'b01000);
    run_op("not",      4'd2,  8'h0F, 8'h33, 1, 8'hF0, 5'b00000);
    run_op("and",      4'd3,  8'hF0, 8'h3C, 1, 8'h30, 5'b00000);
    run_op("or",       4'd4,  8'hF0, 8'h0F, 1, 8'hFF, 5'b00000);
    run_op("xor_z",    4'd5,  8'hAA, 8'hAA, 1, 8'h00, 5'b00010);
    run_op("slt_t",    4'd6,  8'hFE, 8'h01, 1, 8'h00, 5'b00100);
    run_op("slt_f",    4'd6,  8'h01, 8'hFE, 1, 8'h00, 5'b00000);
    run_op("eq_t",     4'd7,  8'h5A, 8'h5A, 1, 8'h00, 5'b00100);
    run_op("eq_f",     4'd7,  8'h5A, 8'h5B, 1, 8'h00, 5'b00000);
    run_op("sll",      4'd8,  8'h81, 8'h09, 1, 8'h02, 5'b00000);
    run_op("srl",      4'd9,  8'h81, 8'h04, 1, 8'h08, 5'b00000);
    run_op("sra",      4'd10, 8'h90, 8'h0B, 1, 8'hF2, 5'b00000);
    run_op("mul_ovf",  4'd11, 8'h10, 8'h11, 9, 8'h10, 5'b01000);
    run_op("mul",      4'd11, 8'h0F, 8'h0F, 9, 8'hE1, 5'b00000);

    // Backpressure: result must hold and new requests must be ignored.
    accept(4'd0, 8'h12, 8'h34);
    wait_valid(lat, rdy_seen);
    check("bp_lat", 32'(lat), 32'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      sel      = 4'd11;
      a        = 8'hFF;
      b        = 8'hFF;
      @(posedge clk);
      #1;
      check("bp_c", 32'(c), 32'h46);
      check("bp_flags", 32'(flags), 32'd0);
      check("bp_ir", 32'(in_ready), 32'd0);
      check("bp_ov", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    handshake("bp");

    run_op("illegal",  4'd13, 8'h12, 8'h34, 1, 8'h00, 5'b00001);

    // Reset in the middle of a multiply.
    accept(4'd11, 8'h10, 8'h11);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mrst_ir", 32'(in_ready), 32'd1);
    check("mrst_ov", 32'(out_valid), 32'd0);
    check("mrst_c", 32'(c), 32'd0);
    check("mrst_flags", 32'(flags), 32'd0);
    ov_seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      ov_seen = ov_seen | out_valid;
    end
    check("mrst_stale", 32'(ov_seen), 32'd0);
    run_op("post_rst", 4'd0,  8'h01, 8'h02, 1, 8'h03, 5'b00000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
